// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state, access owner and counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {OWN_CORE, OWN_DMA} owner_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; req[0]/gnt[0] is the core, req[1]/gnt[1] the DMA.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_dma;

    // Reset to DMA-last so the core wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dma <= 1'b1;
        end else if (advance) begin
            last_dma <= gnt[1];
        end
    end

    always_comb begin
        gnt = req;
        if (req[0] && req[1]) begin
            gnt = last_dma ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory between the Memory stage and a DMA requester, sequencing
// each access over LATENCY cycles and stalling the pipeline while the core waits.
module dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        CoreReqM,
    input  logic        CoreWEM,
    input  logic [31:0] CoreAddrM,
    input  logic [31:0] CoreWDM,
    output logic [31:0] CoreRDM,
    output logic        StallM,
    input  logic        DmaReq,
    input  logic        DmaWE,
    input  logic [31:0] DmaAddr,
    input  logic [31:0] DmaWD,
    output logic        DmaGnt,
    output logic        DmaValid,
    output logic [31:0] DmaRD,
    output logic        MemWE,
    output logic [31:0] MemA,
    output logic [31:0] MemWD,
    input  logic [31:0] MemRD
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t            state, next_state;
    owner_t            owner;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic [31:0]       lat_addr, lat_wd, resp;
    logic [1:0]        gnt;
    logic              grant;
    logic              last_access;

    assign grant       = (state == IDLE) && (CoreReqM || DmaReq);
    assign last_access = (state == ACCESS) && (cnt == '0);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({DmaReq, CoreReqM}),
        .advance (grant),
        .gnt     (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (grant) next_state = ACCESS;
            ACCESS:  if (cnt == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            owner    <= OWN_CORE;
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_wd   <= '0;
            resp     <= '0;
        end else begin
            if (grant) begin
                cnt <= CNT_INIT;
                if (gnt[1]) begin
                    owner    <= OWN_DMA;
                    lat_we   <= DmaWE;
                    lat_addr <= DmaAddr;
                    lat_wd   <= DmaWD;
                end else begin
                    owner    <= OWN_CORE;
                    lat_we   <= CoreWEM;
                    lat_addr <= CoreAddrM;
                    lat_wd   <= CoreWDM;
                end
            end else if (state == ACCESS && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (last_access) begin
                resp <= MemRD;
            end
        end
    end

    always_comb begin
        MemWE    = 1'b0;
        MemA     = '0;
        MemWD    = '0;
        DmaGnt   = grant && gnt[1];
        DmaValid = (state == DONE) && (owner == OWN_DMA);
        StallM   = CoreReqM && !((state == DONE) && (owner == OWN_CORE));
        if (state == ACCESS) begin
            MemA  = lat_addr;
            MemWD = lat_wd;
            MemWE = lat_we && last_access;
        end
    end

    assign CoreRDM = resp;
    assign DmaRD   = resp;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked against
// a transaction-level model that tracks each access by its phase since grant.
module tb_dmem_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        CoreReqM = 1'b0, CoreWEM = 1'b0, DmaReq = 1'b0, DmaWE = 1'b0;
    logic [31:0] CoreAddrM = '0, CoreWDM = '0, DmaAddr = '0, DmaWD = '0, MemRD = '0;
    logic [31:0] CoreRDM, DmaRD, MemA, MemWD;
    logic        StallM, DmaGnt, DmaValid, MemWE;

    logic        b_req = 1'b0;
    logic [31:0] b_addr = '0, b_rd = '0;
    logic [31:0] b_CoreRDM, b_DmaRD, b_MemA, b_MemWD;
    logic        b_StallM, b_DmaGnt, b_DmaValid, b_MemWE;

    int ncmp = 0;
    int nfail = 0;

    // Reference model state: one access at a time, phase 1..L = memory busy, L+1 = done.
    bit          m_busy, m_own_dma, m_last_dma, m_we;
    int          m_phase;
    logic [31:0] m_addr, m_wd, m_resp;
    bit          e_grant, e_win_dma, e_stall, e_gnt, e_valid, e_we, in_access, in_done;
    logic [31:0] e_a, e_wd;

    always #5 clk = ~clk;

    dmem_arbiter #(.LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .CoreReqM(CoreReqM), .CoreWEM(CoreWEM), .CoreAddrM(CoreAddrM), .CoreWDM(CoreWDM),
        .CoreRDM(CoreRDM), .StallM(StallM),
        .DmaReq(DmaReq), .DmaWE(DmaWE), .DmaAddr(DmaAddr), .DmaWD(DmaWD),
        .DmaGnt(DmaGnt), .DmaValid(DmaValid), .DmaRD(DmaRD),
        .MemWE(MemWE), .MemA(MemA), .MemWD(MemWD), .MemRD(MemRD)
    );

    dmem_arbiter #(.LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .CoreReqM(b_req), .CoreWEM(1'b0), .CoreAddrM(b_addr), .CoreWDM(32'h0),
        .CoreRDM(b_CoreRDM), .StallM(b_StallM),
        .DmaReq(1'b0), .DmaWE(1'b0), .DmaAddr(32'h0), .DmaWD(32'h0),
        .DmaGnt(b_DmaGnt), .DmaValid(b_DmaValid), .DmaRD(b_DmaRD),
        .MemWE(b_MemWE), .MemA(b_MemA), .MemWD(b_MemWD), .MemRD(b_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_phase = 0; m_own_dma = 0; m_last_dma = 1; m_we = 0;
        m_addr = '0; m_wd = '0; m_resp = '0;
    endtask

    task automatic model_eval();
        e_grant   = !m_busy && (CoreReqM || DmaReq);
        e_win_dma = DmaReq && (!CoreReqM || !m_last_dma);
        in_access = m_busy && m_phase >= 1 && m_phase <= L;
        in_done   = m_busy && m_phase == L + 1;
        e_stall   = CoreReqM && !(in_done && !m_own_dma);
        e_gnt     = e_grant && e_win_dma;
        e_valid   = in_done && m_own_dma;
        e_we      = in_access && m_we && m_phase == L;
        e_a       = in_access ? m_addr : 32'h0;
        e_wd      = in_access ? m_wd : 32'h0;
    endtask

    task automatic model_step();
        if (!m_busy) begin
            if (e_grant) begin
                m_busy = 1; m_phase = 1; m_own_dma = e_win_dma; m_last_dma = e_win_dma;
                m_we   = e_win_dma ? DmaWE : CoreWEM;
                m_addr = e_win_dma ? DmaAddr : CoreAddrM;
                m_wd   = e_win_dma ? DmaWD : CoreWDM;
            end
        end else begin
            if (m_phase == L) m_resp = MemRD;
            if (m_phase == L + 1) m_busy = 0;
            else m_phase++;
        end
    endtask

    task automatic sample();
        #2;
        model_eval();
        chk("StallM", StallM, e_stall);
        chk("DmaGnt", DmaGnt, e_gnt);
        chk("DmaValid", DmaValid, e_valid);
        chk("MemWE", MemWE, e_we);
        chk("MemA", MemA, e_a);
        chk("MemWD", MemWD, e_wd);
        chk("CoreRDM", CoreRDM, m_resp);
        chk("DmaRD", DmaRD, m_resp);
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
    endtask

    initial begin
        bit core_pend, dma_pend;
        model_reset();
        @(posedge clk); #1;
        sample(); advance();
        rst_n = 1'b1;

        // Uncontended core load, plus LATENCY=1 core load on the second instance
        CoreReqM = 1; CoreWEM = 0; CoreAddrM = 32'h10; MemRD = 32'hDEADBEEF;
        b_req = 1; b_addr = 32'h40; b_rd = 32'hCAFEF00D;
        for (int c = 0; c < 4; c++) begin
            sample();
            chk("ld_stall", StallM, (c < 3) ? 32'd1 : 32'd0);
            chk("ld_we", MemWE, 32'd0);
            if (c == 3) chk("ld_data", CoreRDM, 32'hDEADBEEF);
            if (c < 3) chk("l1_stall", b_StallM, (c < 2) ? 32'd1 : 32'd0);
            if (c == 2) chk("l1_data", b_CoreRDM, 32'hCAFEF00D);
            if (c == 2) b_req = 0;
            advance();
        end

        // Core store
        CoreWEM = 1; CoreAddrM = 32'h20; CoreWDM = 32'h12345678; MemRD = 32'h0;
        for (int c = 0; c < 4; c++) begin
            sample();
            chk("st_we", MemWE, (c == 2) ? 32'd1 : 32'd0);
            if (c == 2) begin
                chk("st_addr", MemA, 32'h20);
                chk("st_wd", MemWD, 32'h12345678);
            end
            advance();
        end
        CoreReqM = 0; CoreWEM = 0;

        // Tie from reset: core first, then DMA, then a second tie goes to the core
        rst_n = 0; sample(); advance(); rst_n = 1;
        CoreReqM = 1; CoreAddrM = 32'h30; DmaReq = 1; DmaWE = 0; DmaAddr = 32'h40; MemRD = 32'h55AA55AA;
        for (int c = 0; c < 16; c++) begin
            sample();
            chk("tie_gnt", DmaGnt, (c == 4 || c == 12) ? 32'd1 : 32'd0);
            chk("tie_valid", DmaValid, (c == 7 || c == 15) ? 32'd1 : 32'd0);
            if (c == 1 || c == 9) chk("tie_core_addr", MemA, 32'h30);
            advance();
            if (c == 3 || c == 11) CoreReqM = 0;
            if (c == 4 || c == 12) DmaReq = 0;
            if (c == 7) begin CoreReqM = 1; DmaReq = 1; end
        end

        // DMA in flight when the core requests
        DmaReq = 1; DmaAddr = 32'h80;
        sample(); chk("fl_gnt", DmaGnt, 32'd1); advance();
        DmaReq = 0; CoreReqM = 1; CoreAddrM = 32'h90;
        for (int c = 1; c < 8; c++) begin
            sample();
            chk("fl_stall", StallM, (c < 7) ? 32'd1 : 32'd0);
            advance();
        end
        CoreReqM = 0;

        // Reset during final ACCESS cycle of a DMA write
        DmaReq = 1; DmaWE = 1; DmaAddr = 32'hA0; DmaWD = 32'hFEEDFACE;
        sample(); advance();
        DmaReq = 0; DmaWE = 0;
        sample(); advance();
        sample();
        chk("rs_we_pre", MemWE, 32'd1);
        rst_n = 0;
        #1;
        chk("rs_we", MemWE, 32'd0);
        chk("rs_a", MemA, 32'd0);
        chk("rs_wd", MemWD, 32'd0);
        chk("rs_valid", DmaValid, 32'd0);
        chk("rs_rd", DmaRD, 32'd0);
        chk("rs_stall", StallM, 32'd0);
        model_reset();
        advance();
        sample(); advance();
        rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            sample(); chk("rs_novalid", DmaValid, 32'd0); advance();
        end

        // Randomized traffic
        core_pend = 0; dma_pend = 0;
        for (int i = 0; i < 400; i++) begin
            if (!core_pend) begin
                CoreReqM = ($urandom_range(0, 2) == 0);
                CoreWEM = 1'($urandom); CoreAddrM = $urandom; CoreWDM = $urandom;
                core_pend = CoreReqM;
            end
            if (!dma_pend) begin
                DmaReq = ($urandom_range(0, 2) == 0);
                DmaWE = 1'($urandom); DmaAddr = $urandom; DmaWD = $urandom;
                dma_pend = DmaReq;
            end
            MemRD = $urandom;
            sample();
            if (CoreReqM && !e_stall) core_pend = 0;
            if (e_gnt) dma_pend = 0;
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-ported data memory between the pipeline Memory stage and a DMA/program-loader requester, and sequences each access over a fixed multi-cycle memory latency. Sits between the Memory-stage request signals (write enable, ALU-result address, store data) and the data memory array. While a core access is outstanding, it stalls the pipeline through `StallM`.

## Interface
- `LATENCY`, 2: cycles the memory array needs per access; legal range 1..15.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `CoreReqM` input 1: Memory stage requests an access (load or store).
- `CoreWEM` input 1: core access is a store.
- `CoreAddrM` input 32: core byte address.
- `CoreWDM` input 32: core store data.
- `CoreRDM` output 32: core load data; valid in the core's DONE cycle.
- `StallM` output 1: holds the pipeline; the core keeps its request stable while this is high.
- `DmaReq` input 1: DMA request; held until `DmaGnt`.
- `DmaWE` input 1: DMA access is a write.
- `DmaAddr` input 32: DMA address.
- `DmaWD` input 32: DMA write data.
- `DmaGnt` output 1: one-cycle pulse; the DMA request was accepted and may be dropped next cycle.
- `DmaValid` output 1: one-cycle pulse; the DMA access completed, and `DmaRD` is valid.
- `DmaRD` output 32: DMA read data.
- `MemWE` output 1: memory write enable.
- `MemA` output 32: memory address.
- `MemWD` output 32: memory write data.
- `MemRD` input 32: memory read data, sampled on the final ACCESS cycle.

## Operation
- FSM states:
  - IDLE → ACCESS when any request is present.
  - ACCESS → DONE when the counter reaches 0.
  - DONE → IDLE unconditionally.
- IDLE grant:
  - Round-robin across the two requesters.
  - If only one requests, that one wins.
  - If both request, the one not granted last wins.
  - Latch addr/WE/WD/owner, load the counter with `LATENCY-1`, and update the last-grant pointer.
  - `DmaGnt` is asserted in this cycle when the DMA wins.
- ACCESS:
  - `MemA` and `MemWD` are driven from the latched values.
  - The counter decrements each cycle.
  - `MemWE` = latched WE only while the counter is 0, so exactly one write strobe per access.
  - While the counter is 0, `MemRD` is captured into the shared response register.
- DONE:
  - Core owner: `StallM` is low and `CoreRDM` shows the response register.
  - DMA owner: `DmaValid` = 1 and `DmaRD` shows the response register.
- `StallM` = `CoreReqM` && !(state==DONE && owner==CORE). It is combinational, so a core request in IDLE stalls in that same cycle.
- In IDLE, `MemA`, `MemWD` and `MemWE` are 0.
- `CoreRDM` and `DmaRD` hold the last captured response at all times. Write accesses also capture `MemRD`; that value is don't-care.
- Requests arriving during ACCESS or DONE are not sampled until the next IDLE.
- A DMA request that loses arbitration stays pending.
- Addresses pass through unmodified; alignment is the requester's responsibility.

## Timing
- Per-access occupancy is `LATENCY`+2 cycles: IDLE grant, `LATENCY` ACCESS cycles, then DONE.
- Core stall length is `LATENCY`+1 cycles for an uncontended access. With a DMA access already in flight, add the remaining cycles of that access.
- Example, `LATENCY`=2, core store at cycle 0:
  - c0: IDLE grant, `StallM`=1.
  - c1: ACCESS, `MemWE`=0.
  - c2: ACCESS, `MemWE`=1.
  - c3: DONE, `StallM`=0.
- Back-to-back requests from the same requester are separated by at least one IDLE cycle. This is intentional and keeps the grant logic single-cycle.
- Reset values (asynchronous, on `rst_n` low):
  - State IDLE, counter 0, owner CORE.
  - Last-grant = DMA, so the core wins the first tie.
  - Latched regs 0, response register 0.
  - All outputs 0, except `StallM`, which follows `CoreReqM`.
- Reset mid-access: the access is abandoned. No `MemWE` is issued after reset assertion, and no `DmaValid` or DONE occurs.

## Structure
- Package `mem_arb_pkg`:
  - `state_t` enum {IDLE, ACCESS, DONE}.
  - `owner_t` enum {OWN_CORE, OWN_DMA}.
  - Localparam `CNT_W` = 4.
- Sub-module `rr_arb2`: a two-requester round-robin with a registered last-grant pointer, updated only on an `advance` input asserted at IDLE grant. Outputs one-hot grant.
- Top: FSM, counter, latches and response register.

## Test plan
- Uncontended core load, `LATENCY`=2, addr 0x10, `MemRD`=0xDEADBEEF:
  - `StallM` is high for c0–c2 and low at c3, with `CoreRDM`=0xDEADBEEF at c3.
  - `MemWE` stays 0 throughout.
- Core store, addr 0x20, data 0x12345678:
  - `MemWE` is high for exactly one cycle (c2) with `MemA`=0x20 and `MemWD`=0x12345678.
- Simultaneous core and DMA requests from reset:
  - Core is granted first.
  - DMA is granted at the next IDLE, with `DmaGnt` pulsing there and `DmaValid` pulsing 3 cycles later.
  - A second tie is granted to the core again.
- DMA in flight when the core requests: `StallM` stays high through the DMA's remaining ACCESS/DONE cycles plus the full core access.
- `rst_n` pulled low during the final ACCESS cycle of a DMA write:
  - `MemWE` drops immediately, and all outputs reach reset values.
  - No `DmaValid` follows; the FSM restarts from IDLE.
- `LATENCY`=1: core load completes with `StallM` high for 2 cycles only.
